// File: rtl/lookup_stage.sv
// ---------------------------------------------------------------------------
// lookup_stage
//
// One level of a binary search-tree lookup pipeline. Each stage reads one
// node from an attached synchronous node RAM and then decides the outcome:
//   - the lookup was already resolved upstream: pass it through unchanged,
//   - the node is invalid: the lookup resolves as a miss,
//   - the node is a leaf: the lookup resolves as a hit with the node result,
//   - the node is internal: pick the left child if key < threshold
//     (unsigned), otherwise the right child. A key equal to the threshold
//     goes right.
//
// Valid semantics: in_valid qualifies all in_* fields for one cycle and
// out_valid qualifies all out_* fields for one cycle. There is no ready
// signal and no backpressure. A lookup accepted in cycle N appears on the
// out_* ports in cycle N+2, and one lookup can be accepted every cycle.
// When out_valid is 0, the other out_* ports hold their previous values.
//
// Pipeline:
//   stage 1 - mem_addr = in_addr (combinational). The RAM returns the node
//             word one clock later. The lookup context (valid, key, done,
//             hit, result) is registered alongside that read.
//   stage 2 - decode mem_dout against the stage-1 context and register
//             every out_* port.
//
// Node word layout (LSB first):
//   threshold [KEY], left child [ADDR], right child [ADDR], result [RES],
//   leaf [1], node_valid [1]. Any bits above these are ignored.
//
// Optional feature: define LOOKUP_STAGE_STATS_EN to add the saturating
// 32-bit counters stat_lookups, stat_hits and stat_misses. The counters are
// cleared by rst.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid..in_result lookup from the previous stage
//   mem_addr            node RAM read address
//   mem_dout            node RAM read data, one clk after mem_addr
//   out_valid..out_result lookup to the next stage
//   stat_*              statistics (only with LOOKUP_STAGE_STATS_EN)
// ---------------------------------------------------------------------------
module lookup_stage #(
   parameter int KEY  = 32,
   parameter int ADDR = 10,
   parameter int DATA = 72,
   parameter int RES  = 16
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            in_valid,
   input  logic [KEY-1:0]  in_key,
   input  logic [ADDR-1:0] in_addr,
   input  logic            in_done,
   input  logic            in_hit,
   input  logic [RES-1:0]  in_result,

   output logic [ADDR-1:0] mem_addr,
   input  logic [DATA-1:0] mem_dout,

`ifdef LOOKUP_STAGE_STATS_EN
   output logic [31:0]     stat_lookups,
   output logic [31:0]     stat_hits,
   output logic [31:0]     stat_misses,
`endif

   output logic            out_valid,
   output logic [KEY-1:0]  out_key,
   output logic [ADDR-1:0] out_addr,
   output logic            out_done,
   output logic            out_hit,
   output logic [RES-1:0]  out_result
);

   // Bit positions of the node word fields
   localparam int LEFT_LSB  = KEY;
   localparam int RIGHT_LSB = KEY + ADDR;
   localparam int RES_LSB   = KEY + 2*ADDR;
   localparam int LEAF_BIT  = RES_LSB + RES;
   localparam int NV_BIT    = LEAF_BIT + 1;
   localparam int NODE_W    = NV_BIT + 1;

   // ------------------------------------------------------------------
   // Stage 1: RAM read address and lookup context
   // ------------------------------------------------------------------
   // Purely combinational, so the address also follows in_addr during reset.
   assign mem_addr = in_addr;

   logic            s1_valid;
   logic [KEY-1:0]  s1_key;
   logic            s1_done;
   logic            s1_hit;
   logic [RES-1:0]  s1_result;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_key    <= '0;
         s1_done   <= 1'b0;
         s1_hit    <= 1'b0;
         s1_result <= '0;
      end else begin
         s1_valid  <= in_valid;
         s1_key    <= in_key;
         s1_done   <= in_done;
         s1_hit    <= in_hit;
         s1_result <= in_result;
      end
   end

   // ------------------------------------------------------------------
   // Node word decode
   // ------------------------------------------------------------------
   logic [KEY-1:0]  node_thr;
   logic [ADDR-1:0] node_left;
   logic [ADDR-1:0] node_right;
   logic [RES-1:0]  node_result;
   logic            node_leaf;
   logic            node_nv;

   assign node_thr    = mem_dout[KEY-1:0];
   assign node_left   = mem_dout[LEFT_LSB  +: ADDR];
   assign node_right  = mem_dout[RIGHT_LSB +: ADDR];
   assign node_result = mem_dout[RES_LSB   +: RES];
   assign node_leaf   = mem_dout[LEAF_BIT];
   assign node_nv     = mem_dout[NV_BIT];

   // Spare upper bits of the node word are deliberately ignored.
   generate
      if (DATA > NODE_W) begin : g_spare
         logic unused_spare;
         assign unused_spare = ^mem_dout[DATA-1:NODE_W];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Stage 2: resolve the lookup against the node
   // ------------------------------------------------------------------
   logic [KEY-1:0]  nxt_key;
   logic [ADDR-1:0] nxt_addr;
   logic            nxt_done;
   logic            nxt_hit;
   logic [RES-1:0]  nxt_result;

   always_comb begin
      // Default: already resolved upstream. Pass the lookup through and
      // ignore the node word.
      nxt_key    = s1_key;
      nxt_addr   = '0;
      nxt_done   = s1_done;
      nxt_hit    = s1_hit;
      nxt_result = s1_result;

      if (!s1_done) begin
         if (!node_nv) begin
            // Walked onto an empty node: resolved miss
            nxt_done   = 1'b1;
            nxt_hit    = 1'b0;
            nxt_result = '0;
         end else if (node_leaf) begin
            nxt_done   = 1'b1;
            nxt_hit    = 1'b1;
            nxt_result = node_result;
         end else begin
            nxt_done   = 1'b0;
            nxt_hit    = 1'b0;
            nxt_result = '0;
            // Unsigned compare; equality goes right
            nxt_addr   = (s1_key < node_thr) ? node_left : node_right;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_key    <= '0;
         out_addr   <= '0;
         out_done   <= 1'b0;
         out_hit    <= 1'b0;
         out_result <= '0;
      end else begin
         out_valid <= s1_valid;
         // Data ports only move for a real lookup so that idle cycles leave
         // a deterministic, held value on the bus.
         if (s1_valid) begin
            out_key    <= nxt_key;
            out_addr   <= nxt_addr;
            out_done   <= nxt_done;
            out_hit    <= nxt_hit;
            out_result <= nxt_result;
         end
      end
   end

`ifdef LOOKUP_STAGE_STATS_EN
   // ------------------------------------------------------------------
   // Statistics. Hits and misses count only lookups that this stage
   // resolves, not pass-throughs that were resolved upstream.
   // ------------------------------------------------------------------
   logic new_hit;
   logic new_miss;

   assign new_hit  = s1_valid && !s1_done &&  node_nv && node_leaf;
   assign new_miss = s1_valid && !s1_done && !node_nv;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_lookups <= '0;
         stat_hits    <= '0;
         stat_misses  <= '0;
      end else begin
         if (s1_valid && (stat_lookups != 32'hFFFF_FFFF))
            stat_lookups <= stat_lookups + 32'd1;
         if (new_hit && (stat_hits != 32'hFFFF_FFFF))
            stat_hits <= stat_hits + 32'd1;
         if (new_miss && (stat_misses != 32'hFFFF_FFFF))
            stat_misses <= stat_misses + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_lookup_stage.sv
// ---------------------------------------------------------------------------
// tb_lookup_stage
//
// Directed bench for lookup_stage with its default parameters. A simple
// synchronous-read RAM model drives mem_dout. Inputs change 1 time unit
// after each rising edge, and outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_lookup_stage;

   localparam int KEY  = 32;
   localparam int ADDR = 10;
   localparam int DATA = 72;
   localparam int RES  = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic            in_valid;
   logic [KEY-1:0]  in_key;
   logic [ADDR-1:0] in_addr;
   logic            in_done;
   logic            in_hit;
   logic [RES-1:0]  in_result;
   logic [ADDR-1:0] mem_addr;
   logic [DATA-1:0] mem_dout;
   logic            out_valid;
   logic [KEY-1:0]  out_key;
   logic [ADDR-1:0] out_addr;
   logic            out_done;
   logic            out_hit;
   logic [RES-1:0]  out_result;
`ifdef LOOKUP_STAGE_STATS_EN
   logic [31:0]     stat_lookups;
   logic [31:0]     stat_hits;
   logic [31:0]     stat_misses;
`endif

   lookup_stage #(.KEY(KEY), .ADDR(ADDR), .DATA(DATA), .RES(RES)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_key     (in_key),
      .in_addr    (in_addr),
      .in_done    (in_done),
      .in_hit     (in_hit),
      .in_result  (in_result),
      .mem_addr   (mem_addr),
      .mem_dout   (mem_dout),
`ifdef LOOKUP_STAGE_STATS_EN
      .stat_lookups (stat_lookups),
      .stat_hits    (stat_hits),
      .stat_misses  (stat_misses),
`endif
      .out_valid  (out_valid),
      .out_key    (out_key),
      .out_addr   (out_addr),
      .out_done   (out_done),
      .out_hit    (out_hit),
      .out_result (out_result)
   );

   // ---------------- node RAM model (1-cycle read) ----------------
   logic [DATA-1:0] ram [0:(1<<ADDR)-1];
   always @(posedge clk) mem_dout <= ram[mem_addr];

   function automatic logic [DATA-1:0] node(input logic [KEY-1:0] thr,
                                            input logic [ADDR-1:0] left,
                                            input logic [ADDR-1:0] right,
                                            input logic [RES-1:0] res,
                                            input logic leaf,
                                            input logic nv);
      return {2'b00, nv, leaf, res, right, left, thr};
   endfunction

   // ---------------- scoreboard counters ----------------
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [KEY-1:0] key, input logic [ADDR-1:0] addr,
                          input logic done, input logic hit, input logic [RES-1:0] res);
      in_valid  = 1'b1;
      in_key    = key;
      in_addr   = addr;
      in_done   = done;
      in_hit    = hit;
      in_result = res;
   endtask

   task automatic idle;
      in_valid  = 1'b0;
      in_done   = 1'b0;
      in_hit    = 1'b0;
      in_result = '0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      for (int i = 0; i < (1<<ADDR); i++) ram[i] = '0;
      ram[5] = node(32'd100, 10'd7, 10'd9, 16'h0000, 1'b0, 1'b1);
      ram[3] = node(32'd0, 10'd0, 10'd0, 16'hBEEF, 1'b1, 1'b1);
      ram[4] = node(32'd0, 10'd1, 10'd2, 16'h7777, 1'b1, 1'b0);
      ram[6] = node(32'h8000_0000, 10'd11, 10'd12, 16'h0000, 1'b0, 1'b1);
      ram[8] = 72'hA5_5A5A_5A5A_5A5A_5A5A;

      rst = 1'b1;
      idle();
      in_key  = '0;
      in_addr = 10'h155;

      // Reset: outputs are 0 from the first edge; mem_addr stays live
      tick();
      chk("rst_valid",  out_valid,  0);
      chk("rst_key",    out_key,    0);
      chk("rst_addr",   out_addr,   0);
      chk("rst_done",   out_done,   0);
      chk("rst_hit",    out_hit,    0);
      chk("rst_result", out_result, 0);
      chk("rst_memaddr", mem_addr, 10'h155);
      in_addr = 10'h02A;
      #1;
      chk("rst_memaddr2", mem_addr, 10'h02A);
`ifdef LOOKUP_STAGE_STATS_EN
      chk("rst_stat_lookups", stat_lookups, 0);
`endif
      tick();
      rst = 1'b0;
      tick();

      // Internal node, key < threshold -> left child, 2-cycle latency
      present(32'd50, 10'd5, 1'b0, 1'b0, 16'h0);
      tick();
      idle();
      chk("lat_early_valid", out_valid, 0);
      tick();
      chk("left_valid", out_valid, 1);
      chk("left_addr",  out_addr,  7);
      chk("left_done",  out_done,  0);
      chk("left_key",   out_key,   50);

      // key == threshold then key > threshold, back to back
      present(32'd100, 10'd5, 1'b0, 1'b0, 16'h0);
      tick();
      present(32'd101, 10'd5, 1'b0, 1'b0, 16'h0);
      tick();
      idle();
      chk("eq_valid", out_valid, 1);
      chk("eq_addr",  out_addr,  9);
      chk("eq_key",   out_key,   100);
      tick();
      chk("gt_valid", out_valid, 1);
      chk("gt_addr",  out_addr,  9);
      chk("gt_key",   out_key,   101);
      tick();
      chk("gap_valid",    out_valid, 0);
      chk("gap_hold_key", out_key,   101);
      chk("gap_hold_addr", out_addr, 9);

      // Unsigned comparison at the top of the key range
      present(32'h7FFF_FFFF, 10'd6, 1'b0, 1'b0, 16'h0);
      tick();
      present(32'hFFFF_FFFF, 10'd5, 1'b0, 1'b0, 16'h0);
      tick();
      idle();
      chk("uns_left_addr", out_addr, 11);
      tick();
      chk("uns_right_addr", out_addr, 9);

      // Leaf hit, then invalid node miss
      present(32'd77, 10'd3, 1'b0, 1'b0, 16'h0);
      tick();
      present(32'd88, 10'd4, 1'b0, 1'b0, 16'h0);
      tick();
      idle();
      chk("leaf_valid",  out_valid,  1);
      chk("leaf_done",   out_done,   1);
      chk("leaf_hit",    out_hit,    1);
      chk("leaf_result", out_result, 16'hBEEF);
      chk("leaf_addr",   out_addr,   0);
      tick();
      chk("miss_done",   out_done,   1);
      chk("miss_hit",    out_hit,    0);
      chk("miss_result", out_result, 0);
      chk("miss_addr",   out_addr,   0);
      chk("miss_key",    out_key,    88);

      // Already resolved upstream: pass-through ignores the RAM
      present(32'h55, 10'd8, 1'b1, 1'b1, 16'h1234);
      tick();
      present(32'h66, 10'd5, 1'b1, 1'b0, 16'h00AB);
      tick();
      idle();
      chk("pass_result", out_result, 16'h1234);
      chk("pass_done",   out_done,   1);
      chk("pass_hit",    out_hit,    1);
      chk("pass_addr",   out_addr,   0);
      chk("pass_key",    out_key,    32'h55);
      tick();
      chk("pass2_result", out_result, 16'h00AB);
      chk("pass2_hit",    out_hit,    0);
      chk("pass2_addr",   out_addr,   0);

      // Reset with two lookups in flight; next lookup emerges normally
      present(32'd50, 10'd5, 1'b0, 1'b0, 16'h0);
      tick();
      present(32'd101, 10'd5, 1'b0, 1'b0, 16'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("flush_valid0", out_valid, 0);
      chk("flush_addr0",  out_addr,  0);
      present(32'd77, 10'd3, 1'b0, 1'b0, 16'h0);
      tick();
      idle();
      chk("flush_valid1", out_valid, 0);
      tick();
      chk("post_rst_valid",  out_valid,  1);
      chk("post_rst_result", out_result, 16'hBEEF);
      chk("post_rst_key",    out_key,    77);
      tick();
      chk("post_rst_idle",   out_valid,  0);

`ifdef LOOKUP_STAGE_STATS_EN
      // Statistics: 4 leaf hits, 3 invalid nodes, 3 internal nodes
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("stat_clr_hits", stat_hits, 0);
      for (int i = 0; i < 10; i++) begin
         present(32'd50, (i < 4) ? 10'd3 : ((i < 7) ? 10'd4 : 10'd5), 1'b0, 1'b0, 16'h0);
         tick();
      end
      idle();
      tick();
      tick();
      chk("stat_lookups", stat_lookups, 10);
      chk("stat_hits",    stat_hits,    4);
      chk("stat_misses",  stat_misses,  3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
